// File: rtl/uart_defs.sv
// Shared UART definitions: transmit FSM state encodings, line levels and
// the frame-length formula used by the tx/rx controllers and their benches.
package uart_defs;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } state_e;

  localparam logic LINE_IDLE  = 1'b1;
  localparam logic LINE_START = 1'b0;

  function automatic int frame_ticks(input int data_bits, input int parity_en,
                                     input int stop_bits);
    return 1 + data_bits + parity_en + stop_bits;
  endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Baud-tick generator: held in phase by baud_en; the first tick arrives
// BAUD_PERIOD cycles after baud_en rises, then one every BAUD_PERIOD cycles.
module uart_baud_gen #(
  parameter int BAUD_PERIOD = 10
) (
  input  logic clk,
  input  logic reset,
  input  logic baud_en,
  output logic baud_tick
);

  localparam int CW = (BAUD_PERIOD > 1) ? $clog2(BAUD_PERIOD) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(BAUD_PERIOD - 1);

  logic [CW-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt_q <= '0;
    end else if (!baud_en) begin
      cnt_q <= '0;
    end else if (cnt_q == CNT_LAST) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + CW'(1);
    end
  end

  // Combinational so the controller advances exactly BAUD_PERIOD edges after enable.
  assign baud_tick = baud_en && (cnt_q == CNT_LAST);

endmodule

// File: rtl/uart_tx_ctrl.sv
// UART transmit sequencer: accepts a word over valid/ready and shifts it out
// as start, LSB-first data, optional parity and stop bits, one bit per baud tick.
module uart_tx_ctrl
  import uart_defs::*;
#(
  parameter int DATA_BITS  = 8,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0,
  parameter int STOP_BITS  = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 tx_valid,
  input  logic [DATA_BITS-1:0] tx_data,
  output logic                 tx_ready,
  input  logic                 baud_tick,
  output logic                 baud_en,
  output logic                 tx,
  output logic                 busy,
  output logic                 tx_done
);

  localparam int CNT_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
  localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(DATA_BITS - 1);
  localparam logic STOP_LAST = 1'(STOP_BITS - 1);
  localparam logic PAR_EN    = 1'(PARITY_EN);
  localparam logic PAR_ODD   = 1'(PARITY_ODD);

  state_e               state_q;
  logic [DATA_BITS-1:0] shift_q;
  logic [CNT_W-1:0]     bit_cnt_q;
  logic                 stop_cnt_q;
  logic                 parity_q;
  logic                 tx_q;
  logic                 tx_ready_q;
  logic                 baud_en_q;
  logic                 busy_q;
  logic                 tx_done_q;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      shift_q    <= '0;
      bit_cnt_q  <= '0;
      stop_cnt_q <= 1'b0;
      parity_q   <= 1'b0;
      tx_q       <= LINE_IDLE;
      tx_ready_q <= 1'b1;
      baud_en_q  <= 1'b0;
      busy_q     <= 1'b0;
      tx_done_q  <= 1'b0;
    end else begin
      tx_done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (tx_valid && tx_ready_q) begin
            shift_q    <= tx_data;
            parity_q   <= (^tx_data) ^ PAR_ODD;
            tx_q       <= LINE_START;
            baud_en_q  <= 1'b1;
            tx_ready_q <= 1'b0;
            busy_q     <= 1'b1;
            state_q    <= ST_START;
          end
        end
        ST_START: begin
          if (baud_tick) begin
            tx_q      <= shift_q[0];
            shift_q   <= shift_q >> 1;
            bit_cnt_q <= '0;
            state_q   <= ST_DATA;
          end
        end
        ST_DATA: begin
          if (baud_tick) begin
            if (bit_cnt_q < BIT_LAST) begin
              tx_q      <= shift_q[0];
              shift_q   <= shift_q >> 1;
              bit_cnt_q <= bit_cnt_q + CNT_W'(1);
            end else if (PAR_EN) begin
              tx_q    <= parity_q;
              state_q <= ST_PARITY;
            end else begin
              tx_q       <= LINE_IDLE;
              stop_cnt_q <= 1'b0;
              state_q    <= ST_STOP;
            end
          end
        end
        ST_PARITY: begin
          if (baud_tick) begin
            tx_q       <= LINE_IDLE;
            stop_cnt_q <= 1'b0;
            state_q    <= ST_STOP;
          end
        end
        ST_STOP: begin
          if (baud_tick) begin
            if (stop_cnt_q < STOP_LAST) begin
              stop_cnt_q <= stop_cnt_q + 1'b1;
            end else begin
              baud_en_q  <= 1'b0;
              busy_q     <= 1'b0;
              tx_ready_q <= 1'b1;
              tx_done_q  <= 1'b1;
              state_q    <= ST_IDLE;
            end
          end
        end
        // Unreachable encodings fall back to a clean idle line.
        default: begin
          state_q    <= ST_IDLE;
          tx_q       <= LINE_IDLE;
          tx_ready_q <= 1'b1;
          baud_en_q  <= 1'b0;
          busy_q     <= 1'b0;
        end
      endcase
    end
  end

  assign tx       = tx_q;
  assign tx_ready = tx_ready_q;
  assign baud_en  = baud_en_q;
  assign busy     = busy_q;
  assign tx_done  = tx_done_q;

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Directed bench for uart_tx_ctrl: four configurations (8N1, 8O1, 8E1, 8N2)
// each paired with a baud generator at BAUD_PERIOD=10.
module tb_uart_tx_ctrl;

  logic       clk;
  logic       reset;
  logic       spur;
  logic       valid_s [4];
  logic [7:0] data_s  [4];
  logic       tx_s    [4];
  logic       rdy_s   [4];
  logic       ben_s   [4];
  logic       busy_s  [4];
  logic       done_s  [4];
  logic       tick_s  [4];

  int n_checks;
  int n_errors;

  uart_tx_ctrl #(.DATA_BITS(8), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1)) u_8n1 (
    .clk(clk), .reset(reset), .tx_valid(valid_s[0]), .tx_data(data_s[0]),
    .tx_ready(rdy_s[0]), .baud_tick(tick_s[0] | spur), .baud_en(ben_s[0]),
    .tx(tx_s[0]), .busy(busy_s[0]), .tx_done(done_s[0]));
  uart_baud_gen #(.BAUD_PERIOD(10)) u_gen0 (
    .clk(clk), .reset(reset), .baud_en(ben_s[0]), .baud_tick(tick_s[0]));

  uart_tx_ctrl #(.DATA_BITS(8), .PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(1)) u_8o1 (
    .clk(clk), .reset(reset), .tx_valid(valid_s[1]), .tx_data(data_s[1]),
    .tx_ready(rdy_s[1]), .baud_tick(tick_s[1]), .baud_en(ben_s[1]),
    .tx(tx_s[1]), .busy(busy_s[1]), .tx_done(done_s[1]));
  uart_baud_gen #(.BAUD_PERIOD(10)) u_gen1 (
    .clk(clk), .reset(reset), .baud_en(ben_s[1]), .baud_tick(tick_s[1]));

  uart_tx_ctrl #(.DATA_BITS(8), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(1)) u_8e1 (
    .clk(clk), .reset(reset), .tx_valid(valid_s[2]), .tx_data(data_s[2]),
    .tx_ready(rdy_s[2]), .baud_tick(tick_s[2]), .baud_en(ben_s[2]),
    .tx(tx_s[2]), .busy(busy_s[2]), .tx_done(done_s[2]));
  uart_baud_gen #(.BAUD_PERIOD(10)) u_gen2 (
    .clk(clk), .reset(reset), .baud_en(ben_s[2]), .baud_tick(tick_s[2]));

  uart_tx_ctrl #(.DATA_BITS(8), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(2)) u_8n2 (
    .clk(clk), .reset(reset), .tx_valid(valid_s[3]), .tx_data(data_s[3]),
    .tx_ready(rdy_s[3]), .baud_tick(tick_s[3]), .baud_en(ben_s[3]),
    .tx(tx_s[3]), .busy(busy_s[3]), .tx_done(done_s[3]));
  uart_baud_gen #(.BAUD_PERIOD(10)) u_gen3 (
    .clk(clk), .reset(reset), .baud_en(ben_s[3]), .baud_tick(tick_s[3]));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Expected line level of frame bit j (0 = start, 1..8 = data, then parity/stop).
  function automatic logic exp_bit(input logic [7:0] d, input int pe, input int od,
                                   input int j);
    if (j == 0) return 1'b0;
    if (j <= 8) return d[j-1];
    if (pe != 0 && j == 9) return (od != 0) ^ (^d);
    return 1'b1;
  endfunction

  // Called at a negedge with unit u idle; checks every cycle of the frame.
  task automatic send_check(input int u, input logic [7:0] d, input int pe,
                            input int od, input int sb, input bit disturb,
                            input string tag);
    int n;
    n = (1 + 8 + pe + sb) * 10;
    valid_s[u] = 1'b1;
    data_s[u]  = d;
    @(negedge clk);
    valid_s[u] = 1'b0;
    chk({tag, ".accept"}, {rdy_s[u], busy_s[u], ben_s[u]}, 3'b011);
    for (int k = 0; k <= n; k++) begin
      if (disturb && k == 35) begin
        data_s[u]  = ~d;
        valid_s[u] = 1'b1;
      end
      if (disturb && k == 37) valid_s[u] = 1'b0;
      if (k < n) chk({tag, ".tx"}, tx_s[u], exp_bit(d, pe, od, k / 10));
      chk({tag, ".done"}, done_s[u], k == n);
      if (k == n) chk({tag, ".end"}, {rdy_s[u], busy_s[u], ben_s[u]}, 3'b100);
      if (k < n) @(negedge clk);
    end
    @(negedge clk);
    chk({tag, ".done_clr"}, {done_s[u], tx_s[u]}, 2'b01);
  endtask

  initial begin
    int ndone;
    clk = 1'b0;
    reset = 1'b0;
    spur = 1'b0;
    n_checks = 0;
    n_errors = 0;
    for (int u = 0; u < 4; u++) begin
      valid_s[u] = 1'b0;
      data_s[u]  = 8'h00;
    end
    repeat (3) @(negedge clk);
    for (int u = 0; u < 4; u++)
      chk("reset", {tx_s[u], rdy_s[u], busy_s[u], ben_s[u], done_s[u]}, 5'b11000);
    reset = 1'b1;

    // Idle with spurious ticks: nothing may move.
    for (int k = 0; k < 50; k++) begin
      spur = (k % 7 == 3);
      @(negedge clk);
      chk("idle", {tx_s[0], rdy_s[0], busy_s[0], ben_s[0], done_s[0]}, 5'b11000);
    end
    spur = 1'b0;

    send_check(0, 8'hA5, 0, 0, 1, 1'b0, "8n1_a5");
    send_check(1, 8'h03, 1, 1, 1, 1'b0, "8o1_03");
    send_check(2, 8'h03, 1, 0, 1, 1'b0, "8e1_03");
    send_check(1, 8'hA4, 1, 1, 1, 1'b0, "8o1_a4");

    // Back-to-back 8N2 frames with tx_valid held high.
    ndone = 0;
    valid_s[3] = 1'b1;
    data_s[3]  = 8'hFF;
    for (int k = 0; k <= 225; k++) begin
      logic e_tx;
      @(negedge clk);
      if (k == 111) valid_s[3] = 1'b0;
      if (k <= 109) e_tx = exp_bit(8'hFF, 0, 0, k / 10);
      else if (k >= 111 && k <= 220) e_tx = exp_bit(8'hFF, 0, 0, (k - 111) / 10);
      else e_tx = 1'b1;
      chk("b2b.tx", tx_s[3], e_tx);
      chk("b2b.done", done_s[3], (k == 110) || (k == 221));
      if (k == 110) chk("b2b.gap", {rdy_s[3], ben_s[3], busy_s[3]}, 3'b100);
      if (k == 111) chk("b2b.restart", {rdy_s[3], ben_s[3], tx_s[3]}, 3'b010);
      ndone += int'(done_s[3]);
    end
    chk("b2b.ndone", ndone, 2);

    send_check(0, 8'h3C, 0, 0, 1, 1'b1, "disturb");

    // Reset taken during data bit 3.
    valid_s[0] = 1'b1;
    data_s[0]  = 8'h5A;
    @(negedge clk);
    valid_s[0] = 1'b0;
    for (int k = 1; k <= 43; k++) begin
      @(negedge clk);
      chk("mid.tx", tx_s[0], exp_bit(8'h5A, 0, 0, k / 10));
      chk("mid.done", done_s[0], 1'b0);
    end
    reset = 1'b0;
    repeat (2) begin
      @(negedge clk);
      chk("mid.rst", {tx_s[0], busy_s[0], ben_s[0], rdy_s[0], done_s[0]}, 5'b10010);
    end
    reset = 1'b1;
    repeat (12) begin
      @(negedge clk);
      chk("mid.after", {tx_s[0], busy_s[0], ben_s[0], rdy_s[0], done_s[0]}, 5'b10010);
    end
    send_check(0, 8'hC3, 0, 0, 1, 1'b0, "post_rst");

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
